// File: rtl/aq_fcnvt_itof_d_pipe.sv
// Three-stage integer to binary64 converter for the vfalu FCNVT path.
// Stages: magnitude + leading-zero count, normalize, round + pack.
module aq_fcnvt_itof_d_pipe #(
  parameter int LAT = 3
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        itof_flush,
  input  logic        itof_in_vld,
  output logic        itof_in_rdy,
  input  logic [63:0] itof_in_src,
  input  logic        itof_in_is_64,
  input  logic        itof_in_signed,
  input  logic [2:0]  itof_in_rm,
  output logic        itof_out_vld,
  input  logic        itof_out_rdy,
  output logic [63:0] itof_out_result,
  output logic        itof_out_nx
);

  if (LAT != 3) begin : g_lat_unsupported
    $error("aq_fcnvt_itof_d_pipe supports LAT=3 only");
  end

  logic s1_vld_q;
  logic s2_vld_q;
  logic s3_vld_q;
  logic s1_free;
  logic s2_free;
  logic s3_free;
  logic in_fire;

  assign s3_free     = ~s3_vld_q | itof_out_rdy;
  assign s2_free     = ~s2_vld_q | s3_free;
  assign s1_free     = ~s1_vld_q | s2_free;
  assign itof_in_rdy = s1_free;
  assign in_fire     = itof_in_vld & s1_free;

  // S1: source select, magnitude, leading-zero count
  logic [63:0] op_d;
  logic        sign_d;
  logic [63:0] mag_d;
  logic        zero_d;
  logic [5:0]  lzc_d;

  always_comb begin
    op_d = itof_in_src;
    if (!itof_in_is_64) begin
      op_d = {{32{itof_in_signed & itof_in_src[31]}},
              itof_in_src[31:0]};
    end
    sign_d = itof_in_signed & op_d[63];
    mag_d  = sign_d ? (~op_d + 64'd1) : op_d;
    zero_d = (mag_d == 64'd0);
  end

  // highest set bit wins since the scan runs upward
  always_comb begin
    lzc_d = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (mag_d[i]) lzc_d = 6'(63 - i);
    end
  end

  logic        s1_sign_q;
  logic        s1_zero_q;
  logic [5:0]  s1_lzc_q;
  logic [63:0] s1_mag_q;
  logic [2:0]  s1_rm_q;

  // S2: normalize
  logic [63:0] norm_d;
  logic [10:0] exp_d;
  logic        s2_zero_d;

  always_comb begin
    norm_d    = s1_mag_q << s1_lzc_q;
    exp_d     = 11'd1086 - {5'd0, s1_lzc_q};
    s2_zero_d = s1_zero_q | ~norm_d[63];
  end

  logic        s2_sign_q;
  logic        s2_zero_q;
  logic [2:0]  s2_rm_q;
  logic [10:0] s2_exp_q;
  logic [51:0] s2_man_q;
  logic        s2_g_q;
  logic        s2_s_q;

  // S3: round and pack
  logic        inc_d;
  logic        inx_d;
  logic [62:0] sum_d;
  logic [63:0] res_d;
  logic        nx_d;

  always_comb begin
    inx_d = s2_g_q | s2_s_q;
    case (s2_rm_q)
      3'd1:    inc_d = 1'b0;
      3'd2:    inc_d = s2_sign_q & inx_d;
      3'd3:    inc_d = ~s2_sign_q & inx_d;
      3'd4:    inc_d = s2_g_q;
      default: inc_d = s2_g_q & (s2_s_q | s2_man_q[0]);
    endcase
    sum_d = {s2_exp_q, s2_man_q} + {62'd0, inc_d};
    res_d = s2_zero_q ? 64'd0 : {s2_sign_q, sum_d};
    nx_d  = ~s2_zero_q & inx_d;
  end

  logic [63:0] s3_res_q;
  logic        s3_nx_q;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b || itof_flush) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
    end else begin
      if (s1_free) s1_vld_q <= itof_in_vld;
      if (s2_free) s2_vld_q <= s1_vld_q;
      if (s3_free) s3_vld_q <= s2_vld_q;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (in_fire) begin
      s1_sign_q <= sign_d;
      s1_zero_q <= zero_d;
      s1_lzc_q  <= lzc_d;
      s1_mag_q  <= mag_d;
      s1_rm_q   <= itof_in_rm;
    end
    if (s2_free && s1_vld_q) begin
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s2_zero_d;
      s2_rm_q   <= s1_rm_q;
      s2_exp_q  <= exp_d;
      s2_man_q  <= norm_d[62:11];
      s2_g_q    <= norm_d[10];
      s2_s_q    <= |norm_d[9:0];
    end
    if (s3_free && s2_vld_q) begin
      s3_res_q <= res_d;
      s3_nx_q  <= nx_d;
    end
  end

  assign itof_out_vld    = s3_vld_q;
  assign itof_out_result = s3_vld_q ? s3_res_q : 64'd0;
  assign itof_out_nx     = s3_vld_q & s3_nx_q;

endmodule
